// File: rtl/gerador_eco_cm_if.sv
// -----------------------------------------------------------------------------
// gerador_eco_cm_if
// Bundle between a trigger/distance source and the echo emulator.
//
// Signals:
//   trigger    source -> emulator  trigger request, level
//   distancia  source -> emulator  BCD distance {hundreds, tens, units}
//   eco        emulator -> source  echo pulse
//   ocupado    emulator -> source  busy from accepted trigger through pronto
//   pronto     emulator -> source  1-cycle pulse after the echo completes
//   erro       emulator -> source  1-cycle pulse on an invalid BCD digit
//
// Modports:
//   master  the side that issues triggers (testbench, measurement chain)
//   slave   the echo emulator itself
// -----------------------------------------------------------------------------
interface gerador_eco_cm_if;
    logic        trigger;
    logic [11:0] distancia;
    logic        eco;
    logic        ocupado;
    logic        pronto;
    logic        erro;

    modport master (
        output trigger,
        output distancia,
        input  eco,
        input  ocupado,
        input  pronto,
        input  erro
    );

    modport slave (
        input  trigger,
        input  distancia,
        output eco,
        output ocupado,
        output pronto,
        output erro
    );
endinterface

// File: rtl/gerador_eco_cm.sv
// -----------------------------------------------------------------------------
// gerador_eco_cm
// Ultrasonic sensor echo emulator. Accepts a trigger pulse of at least
// TRIG_MIN_TICKS cycles, latches a 3-digit BCD distance when the trigger
// falls, waits ECHO_DELAY cycles and then drives an echo pulse that is
// N*TICKS_PER_CM cycles wide, where N is the latched distance in cm.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-high; wins over everything
//   bus     gerador_eco_cm_if.slave
//             trigger   in   trigger request, level, already synchronised
//             distancia in   BCD distance, sampled when the trigger is accepted
//             eco       out  echo pulse, registered
//             ocupado   out  high in ATRASO, ECO and FIM
//             pronto    out  1-cycle pulse after the echo completes
//             erro      out  1-cycle pulse when a latched digit is > 9
//
// Configuration macro:
//   ECO_TIMEOUT_EN  when defined, a latched distance above MAX_CM skips the
//                   BCD countdown and holds eco for exactly TIMEOUT_TICKS
//                   cycles (no-target behaviour of the real sensor).
//                   When undefined, MAX_CM and TIMEOUT_TICKS have no effect.
//
// All outputs are registered and decoded from the next state, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module gerador_eco_cm #(
    parameter int unsigned TICKS_PER_CM   = 2941,
    parameter int unsigned TRIG_MIN_TICKS = 500,
    parameter int unsigned ECHO_DELAY     = 25000,
    parameter int unsigned MAX_CM         = 400,
    parameter int unsigned TIMEOUT_TICKS  = 1900000
) (
    input  logic            clock,
    input  logic            reset,
    gerador_eco_cm_if.slave bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] INICIAL   = 3'd0;
    localparam logic [2:0] ESPERA    = 3'd1;
    localparam logic [2:0] MEDE_TRIG = 3'd2;
    localparam logic [2:0] ERRO      = 3'd3;
    localparam logic [2:0] ATRASO    = 3'd4;
    localparam logic [2:0] ECO       = 3'd5;
    localparam logic [2:0] FIM       = 3'd6;

    // ------------------------------------------------------------------
    // Counter sizing. One shared counter times the delay, the per-cm tick
    // and (optionally) the timeout, since those phases never overlap.
    // ------------------------------------------------------------------
    localparam int unsigned TRIG_W   = $clog2(TRIG_MIN_TICKS + 1);
    localparam int unsigned DLY_TOP  = ECHO_DELAY - 1;
    localparam int unsigned TICK_TOP = TICKS_PER_CM - 1;
    localparam int unsigned BASE_TOP = (DLY_TOP > TICK_TOP) ? DLY_TOP : TICK_TOP;
`ifdef ECO_TIMEOUT_EN
    localparam int unsigned TMO_TOP  = TIMEOUT_TICKS - 1;
    localparam int unsigned CNT_TOP  = (TMO_TOP > BASE_TOP) ? TMO_TOP : BASE_TOP;
    // MAX_CM in BCD; for valid digits BCD order equals numeric order.
    localparam logic [11:0] MAX_BCD  = {4'(MAX_CM / 100), 4'((MAX_CM / 10) % 10), 4'(MAX_CM % 10)};
`else
    localparam int unsigned CNT_TOP  = BASE_TOP;
`endif
    localparam int unsigned CNT_W    = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);

    // Reject parameter sets the FSM cannot honour.
    if (TICKS_PER_CM < 1 || TRIG_MIN_TICKS < 1 || ECHO_DELAY < 1 ||
        MAX_CM > 999 || TIMEOUT_TICKS < 1) begin : g_param_invalid
        $error("gerador_eco_cm: invalid parameter set");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [TRIG_W-1:0] trig_q,  trig_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [11:0]       bcd_q,   bcd_d;
`ifdef ECO_TIMEOUT_EN
    logic              tmo_q,   tmo_d;
`endif
    logic              eco_q;
    logic              ocupado_q;
    logic              pronto_q;
    logic              erro_q;

    logic [11:0]       bcd_dec;
    logic              digito_inv;

    // Any digit of the incoming distance outside 0..9.
    assign digito_inv = (bus.distancia[11:8] > 4'd9) ||
                        (bus.distancia[7:4]  > 4'd9) ||
                        (bus.distancia[3:0]  > 4'd9);

    // BCD down-count by one: units borrow into tens, tens into hundreds.
    always_comb begin
        bcd_dec = bcd_q;
        if (bcd_q[3:0] != 4'd0) begin
            bcd_dec[3:0] = bcd_q[3:0] - 4'd1;
        end else begin
            bcd_dec[3:0] = 4'd9;
            if (bcd_q[7:4] != 4'd0) begin
                bcd_dec[7:4] = bcd_q[7:4] - 4'd1;
            end else begin
                bcd_dec[7:4]  = 4'd9;
                bcd_dec[11:8] = bcd_q[11:8] - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        trig_d  = trig_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef ECO_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            INICIAL: begin
                state_d = ESPERA;
            end

            ESPERA: begin
                if (bus.trigger) begin
                    state_d = MEDE_TRIG;
                    trig_d  = TRIG_W'(1);
                end
            end

            MEDE_TRIG: begin
                if (bus.trigger) begin
                    if (trig_q < TRIG_W'(TRIG_MIN_TICKS)) begin
                        trig_d = trig_q + TRIG_W'(1);
                    end
                end else if (trig_q < TRIG_W'(TRIG_MIN_TICKS)) begin
                    // Too short: treated as a glitch.
                    state_d = ESPERA;
                end else begin
                    bcd_d   = bus.distancia;
                    cnt_d   = '0;
                    state_d = digito_inv ? ERRO : ATRASO;
                end
            end

            ERRO: begin
                state_d = ESPERA;
            end

            ATRASO: begin
                if (cnt_q == CNT_W'(DLY_TOP)) begin
                    cnt_d = '0;
                    if (bcd_q == 12'h000) begin
                        state_d = FIM;
                    end else begin
                        state_d = ECO;
`ifdef ECO_TIMEOUT_EN
                        tmo_d   = (bcd_q > MAX_BCD);
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ECO: begin
`ifdef ECO_TIMEOUT_EN
                if (tmo_q) begin
                    if (cnt_q == CNT_W'(TMO_TOP)) begin
                        cnt_d   = '0;
                        state_d = FIM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else
`endif
                if (cnt_q == CNT_W'(TICK_TOP)) begin
                    // One cm elapsed; the wrap that reaches 000 ends the echo.
                    cnt_d = '0;
                    bcd_d = bcd_dec;
                    if (bcd_q == 12'h001) begin
                        state_d = FIM;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FIM: begin
                state_d = ESPERA;
            end

            default: begin
                state_d = INICIAL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INICIAL;
            trig_q    <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
`ifdef ECO_TIMEOUT_EN
            tmo_q     <= 1'b0;
`endif
            eco_q     <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= trig_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
`ifdef ECO_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
            // Decoding the next state keeps outputs aligned with state_q.
            eco_q     <= (state_d == ECO);
            ocupado_q <= (state_d == ATRASO) || (state_d == ECO) || (state_d == FIM);
            pronto_q  <= (state_d == FIM);
            erro_q    <= (state_d == ERRO);
        end
    end

    assign bus.eco     = eco_q;
    assign bus.ocupado = ocupado_q;
    assign bus.pronto  = pronto_q;
    assign bus.erro    = erro_q;

endmodule
